// File: rtl/cs_y_packer.sv
// Serial-to-parallel packer for CS measurements: collects NUM_Y samples
// into one packed block word and hands it downstream with valid/ready.
module cs_y_packer #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_Y      = 32,
    parameter int CNT_W      = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DATA_WIDTH-1:0]       y_in,
    input  logic                        y_valid,
    input  logic                        y_last,
    output logic                        y_ready,
    output logic [NUM_Y*DATA_WIDTH-1:0] y_packed_out,
    output logic                        pkt_valid,
    input  logic                        pkt_ready,
    output logic                        frame_err,
    output logic [15:0]                 pkt_count
);

    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NUM_Y - 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                                state;
    state_t                                state_n;
    logic   [CNT_W-1:0]                    slot;
    logic   [NUM_Y-1:0][DATA_WIDTH-1:0]    mem;
    logic                                  accept;
    logic                                  handshake;
    logic                                  err_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        accept    = 1'b0;
        handshake = 1'b0;
        err_n     = 1'b0;
        unique case (state)
            FILL: begin
                accept = y_valid;
                if (accept && (y_last || slot == LAST_SLOT)) begin
                    state_n = HOLD;
                    // Early last or missing last both close the block misaligned.
                    err_n   = y_last ^ (slot == LAST_SLOT);
                end
            end
            HOLD: begin
                handshake = pkt_ready;
                if (handshake) begin
                    state_n = FILL;
                end
            end
            default: state_n = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot      <= '0;
            mem       <= '0;
            frame_err <= 1'b0;
            pkt_count <= '0;
        end else begin
            frame_err <= err_n;
            if (accept) begin
                mem[slot] <= y_in;
                slot      <= slot + 1'b1;
            end
            if (handshake) begin
                mem       <= '0;
                slot      <= '0;
                pkt_count <= pkt_count + 16'd1;
            end
        end
    end

    // Ready is a pure function of state so upstream sees no combinational loop.
    assign y_ready      = rst_n && (state == FILL);
    assign pkt_valid    = (state == HOLD);
    assign y_packed_out = mem;

endmodule

// File: tb/tb_cs_y_packer.sv
// Scoreboard bench for cs_y_packer: driver queues expected packets,
// a monitor pops and compares on every output handshake.
module tb_cs_y_packer;

    localparam int DW = 16;
    localparam int NY = 32;
    localparam int PW = DW * NY;

    typedef struct {
        logic [PW-1:0] data;
        logic [15:0]   cnt;
    } pkt_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] y_in = '0;
    logic          y_valid = 1'b0;
    logic          y_last = 1'b0;
    logic          y_ready;
    logic [PW-1:0] y_packed_out;
    logic          pkt_valid;
    logic          pkt_ready = 1'b1;
    logic          frame_err;
    logic [15:0]   pkt_count;

    int            tests = 0;
    int            fails = 0;
    int            errs = 0;
    logic          prev_fe = 1'b0;
    logic [15:0]   exp_cnt = '0;
    logic [DW-1:0] blk [NY];
    pkt_t          q [$];

    cs_y_packer #(.DATA_WIDTH(DW), .NUM_Y(NY), .CNT_W(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .y_in         (y_in),
        .y_valid      (y_valid),
        .y_last       (y_last),
        .y_ready      (y_ready),
        .y_packed_out (y_packed_out),
        .pkt_valid    (pkt_valid),
        .pkt_ready    (pkt_ready),
        .frame_err    (frame_err),
        .pkt_count    (pkt_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [PW-1:0] act,
                         input logic [PW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] pack(input int n);
        logic [PW-1:0] r;
        r = '0;
        for (int k = 0; k < n; k++) r[DW*k +: DW] = blk[k];
        return r;
    endfunction

    task automatic expect_pkt(input int n);
        pkt_t p;
        p.data = pack(n);
        p.cnt  = exp_cnt;
        q.push_back(p);
        exp_cnt = exp_cnt + 16'd1;
    endtask

    task automatic send(input int n, input int last_at, input bit gap);
        int tries;
        bit acc;
        for (int k = 0; k < n; k++) begin
            if (gap && k > 0) begin
                @(negedge clk);
                y_valid = 1'b0;
            end
            tries = 0;
            do begin
                @(negedge clk);
                y_valid = 1'b1;
                y_in    = blk[k];
                y_last  = (k == last_at);
                acc     = y_ready;
                tries++;
            end while (!acc && tries < 100);
            if (!acc) begin
                tests++;
                fails++;
                $display("FAIL accept_timeout: sample %0d not accepted", k);
            end
        end
        @(negedge clk);
        y_valid = 1'b0;
        y_last  = 1'b0;
    endtask

    // Monitor: compares every output handshake against the scoreboard.
    initial begin
        pkt_t p;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && pkt_valid && pkt_ready) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_pkt: got %h", y_packed_out);
                end else begin
                    p = q.pop_front();
                    check("pkt_data", y_packed_out, p.data);
                    check("pkt_count_at_hs", PW'(pkt_count), PW'(p.cnt));
                end
            end
            if (frame_err) begin
                errs++;
                if (prev_fe) check("frame_err_width", 1, 0);
            end
            prev_fe = frame_err;
        end
    end

    initial begin
        int e0;
        // 1 reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_pkt_valid", PW'(pkt_valid), 0);
        check("rst_y_ready", PW'(y_ready), 0);
        check("rst_packed", y_packed_out, 0);
        check("rst_count", PW'(pkt_count), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", PW'(y_ready), 1);

        // 2 nominal
        for (int k = 0; k < NY; k++) blk[k] = DW'(k + 1);
        expect_pkt(NY);
        e0 = errs;
        send(NY, NY - 1, 0);
        check("lat_pkt_valid", PW'(pkt_valid), 1);
        check("nom_lo", PW'(y_packed_out[15:0]), PW'(16'd1));
        check("nom_hi", PW'(y_packed_out[511:496]), PW'(16'd32));
        @(negedge clk);
        check("nom_count", PW'(pkt_count), 1);
        check("nom_ready_back", PW'(y_ready), 1);
        check("nom_no_err", PW'(errs - e0), 0);

        // 3 backpressure, with ignored samples offered during HOLD
        for (int k = 0; k < NY; k++) blk[k] = DW'(16'h0100 + k);
        pkt_ready = 1'b0;
        expect_pkt(NY);
        send(NY, NY - 1, 0);
        for (int i = 0; i < 10; i++) begin
            y_valid = 1'b1;
            y_in    = 16'hDEAD;
            check("bp_y_ready", PW'(y_ready), 0);
            check("bp_hold", y_packed_out, pack(NY));
            @(negedge clk);
        end
        y_valid   = 1'b0;
        pkt_ready = 1'b1;
        check("bp_valid_before", PW'(y_ready), 0);
        @(negedge clk);
        check("bp_ready_next", PW'(y_ready), 1);
        check("bp_valid_drop", PW'(pkt_valid), 0);
        check("bp_count", PW'(pkt_count), 2);

        // 4 gapped input
        for (int k = 0; k < NY; k++) blk[k] = DW'(k + 1);
        expect_pkt(NY);
        send(NY, NY - 1, 1);
        check("gap_valid", PW'(pkt_valid), 1);
        @(negedge clk);
        check("gap_count", PW'(pkt_count), 3);

        // 5 early last at k=4
        for (int k = 0; k < NY; k++) blk[k] = 16'hAAAA;
        e0 = errs;
        expect_pkt(5);
        send(5, 4, 0);
        check("early_valid", PW'(pkt_valid), 1);
        repeat (2) @(negedge clk);
        check("early_err", PW'(errs - e0), 1);

        // 6 missing last, then reset mid-block
        for (int k = 0; k < NY; k++) blk[k] = DW'(16'h5000 + k);
        e0 = errs;
        expect_pkt(NY);
        send(NY, -1, 0);
        check("miss_valid", PW'(pkt_valid), 1);
        repeat (2) @(negedge clk);
        check("miss_err", PW'(errs - e0), 1);
        check("miss_count", PW'(pkt_count), 5);
        for (int k = 0; k < NY; k++) blk[k] = DW'(16'h7000 + k);
        send(10, -1, 0);
        rst_n   = 1'b0;
        y_valid = 1'b1;
        y_in    = 16'hBEEF;
        repeat (2) @(negedge clk);
        check("mid_rst_ready", PW'(y_ready), 0);
        check("mid_rst_valid", PW'(pkt_valid), 0);
        check("mid_rst_packed", y_packed_out, 0);
        check("mid_rst_count", PW'(pkt_count), 0);
        check("mid_rst_err", PW'(frame_err), 0);
        y_valid = 1'b0;
        rst_n   = 1'b1;
        exp_cnt = '0;
        for (int k = 0; k < NY; k++) blk[k] = DW'(k + 1);
        expect_pkt(NY);
        send(NY, NY - 1, 0);
        check("fresh_valid", PW'(pkt_valid), 1);
        repeat (2) @(negedge clk);
        check("fresh_count", PW'(pkt_count), 1);
        check("sb_empty", PW'(q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout");
        $fatal(1);
    end

endmodule
